// File: rtl/ktop_pkg.sv
// Shared types and elaboration helpers for the ktop multi-stream adder datapath.
package ktop_pkg;

  // Input-side packet tracking state.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_e;

  // Default configuration of the kernel datapath.
  localparam int unsigned LP_DEF_TDATA_WIDTH = 512;
  localparam int unsigned LP_DEF_ADDER_WIDTH = 32;
  localparam int unsigned LP_DEF_NUM_INPUTS  = 4;
  localparam int unsigned LP_DEF_PIPE_STAGES = 2;

  // Number of adder lanes carried in one beat.
  function automatic int unsigned num_lanes(input int unsigned dw, input int unsigned lw);
    return dw / lw;
  endfunction

  // Width needed to hold the constant plus n lane values without overflow.
  function automatic int unsigned sum_width(input int unsigned lw, input int unsigned n);
    return lw + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ktop_pipe_stage.sv
// Valid/ready register slice; only the valid flag is reset, payload is don't-care when empty.
module ktop_pipe_stage #(
  parameter int unsigned P_WIDTH = 1
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               in_valid,
  output logic               in_ready_c,
  input  logic [P_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] out_data
);

  // Slot can take a new beat when empty or when its content leaves this cycle.
  assign in_ready_c = ~out_valid | out_ready;

  // Occupancy flag follows the upstream valid whenever the slot loads.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
    end else if (in_ready_c) begin
      out_valid <= in_valid;
    end
  end

  // Payload captured only on an actual transfer so a stalled beat stays stable.
  always_ff @(posedge aclk) begin
    if (in_ready_c && in_valid) begin
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/ktop_multi_stream_adder.sv
// N-input AXI4-Stream join/adder: lane-wise sum of all inputs plus a per-packet constant,
// wrap or unsigned-saturate per packet, followed by a stall-able register pipeline.
module ktop_multi_stream_adder
  import ktop_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = LP_DEF_TDATA_WIDTH,
  parameter int unsigned C_ADDER_BIT_WIDTH  = LP_DEF_ADDER_WIDTH,
  parameter int unsigned C_NUM_INPUTS       = LP_DEF_NUM_INPUTS,
  parameter int unsigned C_PIPE_STAGES      = LP_DEF_PIPE_STAGES
) (
  input  logic                                           aclk,
  input  logic                                           areset,
  input  logic [C_ADDER_BIT_WIDTH-1:0]                   ctrl_constant,
  input  logic                                           ctrl_saturate,
  input  logic [C_NUM_INPUTS-1:0]                        s_axis_tvalid,
  output logic [C_NUM_INPUTS-1:0]                        s_axis_tready,
  input  logic [C_NUM_INPUTS*C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_NUM_INPUTS*C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_NUM_INPUTS-1:0]                        s_axis_tlast,
  output logic                                           m_axis_tvalid,
  input  logic                                           m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]                m_axis_tkeep,
  output logic                                           m_axis_tlast,
  output logic [31:0]                                    stat_beat_count,
  output logic                                           stat_last_mismatch
);

  localparam int unsigned LP_DW        = C_AXIS_TDATA_WIDTH;
  localparam int unsigned LP_LW        = C_ADDER_BIT_WIDTH;
  localparam int unsigned LP_N         = C_NUM_INPUTS;
  localparam int unsigned LP_KW        = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned LP_PIPE      = C_PIPE_STAGES;
  localparam int unsigned LP_NUM_LANES = num_lanes(LP_DW, LP_LW);
  localparam int unsigned LP_SUM_W     = sum_width(LP_LW, LP_N);
  localparam int unsigned LP_PW        = LP_DW + LP_KW + 1;

  pkt_state_e         state;
  logic [LP_LW-1:0]   lat_const;
  logic               lat_sat;
  logic [LP_LW-1:0]   eff_const_c;
  logic               eff_sat_c;
  logic               accept_c;
  logic               tlast_uniform_c;
  logic [LP_SUM_W-1:0] acc;
  logic [LP_DW-1:0]   sum_data_c;
  logic [LP_KW-1:0]   keep_c;

  logic [LP_PIPE-1:0] stg_in_valid;
  logic [LP_PIPE-1:0] stg_in_ready_c;
  logic [LP_PIPE-1:0] stg_out_valid;
  logic [LP_PIPE-1:0] stg_out_ready;
  logic [LP_PW-1:0]   stg_in_data  [LP_PIPE];
  logic [LP_PW-1:0]   stg_out_data [LP_PIPE];

  // Join: every input is consumed together; ready never depends on valid and is held low in reset.
  assign accept_c      = (&s_axis_tvalid) & stg_in_ready_c[0] & ~areset;
  assign s_axis_tready = {LP_N{stg_in_ready_c[0] & ~areset}};

  // First beat of a packet uses the live controls; later beats use the values latched on that beat.
  assign eff_const_c = (state == ST_IDLE) ? ctrl_constant : lat_const;
  assign eff_sat_c   = (state == ST_IDLE) ? ctrl_saturate : lat_sat;

  assign tlast_uniform_c = (&s_axis_tlast) | ~(|s_axis_tlast);

  // Per-lane adder tree with carry-out detection for saturation.
  always_comb begin
    sum_data_c = '0;
    acc        = '0;
    for (int l = 0; l < int'(LP_NUM_LANES); l++) begin
      acc = LP_SUM_W'(eff_const_c);
      for (int k = 0; k < int'(LP_N); k++) begin
        acc = acc + LP_SUM_W'(s_axis_tdata[k*int'(LP_DW) + l*int'(LP_LW) +: LP_LW]);
      end
      if (eff_sat_c && (|acc[LP_SUM_W-1:LP_LW])) begin
        sum_data_c[l*int'(LP_LW) +: LP_LW] = '1;
      end else begin
        sum_data_c[l*int'(LP_LW) +: LP_LW] = acc[LP_LW-1:0];
      end
    end
  end

  // Output keep is the intersection of all input keeps.
  always_comb begin
    keep_c = '1;
    for (int k = 0; k < int'(LP_N); k++) begin
      keep_c = keep_c & s_axis_tkeep[k*int'(LP_KW) +: LP_KW];
    end
  end

  // Packet tracking on the input side; advances only on accepted beats.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      lat_const <= '0;
      lat_sat   <= 1'b0;
    end else if (accept_c) begin
      case (state)
        ST_IDLE: begin
          lat_const <= ctrl_constant;
          lat_sat   <= ctrl_saturate;
          state     <= s_axis_tlast[0] ? ST_IDLE : ST_IN_PKT;
        end
        ST_IN_PKT: begin
          state <= s_axis_tlast[0] ? ST_IDLE : ST_IN_PKT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output beat counter and sticky tlast-consistency flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_beat_count    <= '0;
      stat_last_mismatch <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        stat_beat_count <= stat_beat_count + 32'd1;
      end
      if (accept_c && !tlast_uniform_c) begin
        stat_last_mismatch <= 1'b1;
      end
    end
  end

  // Register pipeline: stage 0 captures the adder result, later stages only delay.
  for (genvar i = 0; i < int'(LP_PIPE); i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stg_in_valid[i] = accept_c;
      assign stg_in_data[i]  = {sum_data_c, keep_c, s_axis_tlast[0]};
    end else begin : g_body
      assign stg_in_valid[i] = stg_out_valid[i-1];
      assign stg_in_data[i]  = stg_out_data[i-1];
    end

    if (i == int'(LP_PIPE) - 1) begin : g_tail
      assign stg_out_ready[i] = m_axis_tready;
    end else begin : g_link
      assign stg_out_ready[i] = stg_in_ready_c[i+1];
    end

    ktop_pipe_stage #(
      .P_WIDTH (LP_PW)
    ) u_stage (
      .aclk       (aclk),
      .areset     (areset),
      .in_valid   (stg_in_valid[i]),
      .in_ready_c (stg_in_ready_c[i]),
      .in_data    (stg_in_data[i]),
      .out_valid  (stg_out_valid[i]),
      .out_ready  (stg_out_ready[i]),
      .out_data   (stg_out_data[i])
    );
  end

  assign m_axis_tvalid = stg_out_valid[LP_PIPE-1];
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = stg_out_data[LP_PIPE-1];

endmodule

// File: tb/tb_ktop_multi_stream_adder.sv
// Directed self-checking bench for ktop_multi_stream_adder (default configuration).
module tb_ktop_multi_stream_adder;

  localparam int DW = 512;
  localparam int LW = 32;
  localparam int N  = 4;
  localparam int NL = DW / LW;
  localparam int KW = DW / 8;

  logic            aclk = 1'b0;
  logic            areset;
  logic [LW-1:0]   ctrl_constant;
  logic            ctrl_saturate;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N-1:0]    s_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tlast;
  logic [31:0]     stat_beat_count;
  logic            stat_last_mismatch;

  int checks    = 0;
  int errors    = 0;
  int exp_beats = 0;

  always #5 aclk = ~aclk;

  ktop_multi_stream_adder dut (
    .aclk               (aclk),
    .areset             (areset),
    .ctrl_constant      (ctrl_constant),
    .ctrl_saturate      (ctrl_saturate),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tkeep       (s_axis_tkeep),
    .s_axis_tlast       (s_axis_tlast),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tlast       (m_axis_tlast),
    .stat_beat_count    (stat_beat_count),
    .stat_last_mismatch (stat_last_mismatch)
  );

  // Beat whose lane j holds base + step*j.
  function automatic logic [DW-1:0] lanes(input logic [31:0] base, input logic [31:0] step);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < NL; j++) r[j*LW +: LW] = base + step * 32'(j);
    return r;
  endfunction

  task automatic drive(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                       input logic [N-1:0] vld, input logic [N-1:0] lst);
    s_axis_tdata  = {d3, d2, d1, d0};
    s_axis_tvalid = vld;
    s_axis_tlast  = lst;
    s_axis_tkeep  = '1;
  endtask

  task automatic idle();
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
  endtask

  task automatic test_reset();
    areset        = 1'b1;
    ctrl_constant = '0;
    ctrl_saturate = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    idle();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got %b exp 0", m_axis_tvalid); end
    checks++;
    if (s_axis_tready !== 4'h0) begin errors++; $display("FAIL reset_sready got %h exp 0", s_axis_tready); end
    checks++;
    if (stat_beat_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", stat_beat_count); end
    checks++;
    if (stat_last_mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b exp 0", stat_last_mismatch); end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 4'hF) begin errors++; $display("FAIL post_reset_sready got %h exp f", s_axis_tready); end
  endtask

  task automatic test_basic();
    logic exp_v;
    ctrl_constant = 32'd5;
    ctrl_saturate = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge aclk);
      exp_v = (c >= 2) && (c <= 9);
      checks++;
      if (m_axis_tvalid !== exp_v) begin
        errors++; $display("FAIL basic_valid cycle %0d got %b exp %b", c, m_axis_tvalid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (m_axis_tdata !== lanes(32'd5, 32'd4) || m_axis_tlast !== (c == 9) || m_axis_tkeep !== {KW{1'b1}}) begin
          errors++;
          $display("FAIL basic_beat cycle %0d got %h last %b exp %h last %b", c, m_axis_tdata, m_axis_tlast,
                   lanes(32'd5, 32'd4), (c == 9));
        end
      end
      if (c < 8) drive(lanes(0, 1), lanes(0, 1), lanes(0, 1), lanes(0, 1), 4'hF, (c == 7) ? 4'hF : 4'h0);
      else idle();
    end
    exp_beats += 8;
    checks++;
    if (stat_beat_count !== 32'(exp_beats)) begin
      errors++; $display("FAIL basic_count got %0d exp %0d", stat_beat_count, exp_beats);
    end
  endtask

  task automatic test_saturate();
    @(negedge aclk);
    m_axis_tready = 1'b1;
    ctrl_constant = 32'h20;
    ctrl_saturate = 1'b1;
    drive(lanes(32'hFFFF_FFF0, 0), lanes(32'hFFFF_FFF0, 0), lanes(32'hFFFF_FFF0, 0),
          lanes(32'hFFFF_FFF0, 0), 4'hF, 4'hF);
    @(negedge aclk);
    ctrl_saturate = 1'b0;
    @(negedge aclk);
    idle();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== lanes(32'hFFFF_FFFF, 0)) begin
      errors++; $display("FAIL sat_on got v=%b %h exp %h", m_axis_tvalid, m_axis_tdata, lanes(32'hFFFF_FFFF, 0));
    end
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== lanes(32'hFFFF_FFE0, 0)) begin
      errors++; $display("FAIL sat_off got v=%b %h exp %h", m_axis_tvalid, m_axis_tdata, lanes(32'hFFFF_FFE0, 0));
    end
    @(negedge aclk);
    exp_beats += 2;
    checks++;
    if (stat_beat_count !== 32'(exp_beats)) begin
      errors++; $display("FAIL sat_count got %0d exp %0d", stat_beat_count, exp_beats);
    end
  endtask

  task automatic test_skew();
    logic [KW-1:0] exp_keep;
    exp_keep      = 64'h00FF_FFFF_0000_FFFF;
    ctrl_constant = 32'd0;
    ctrl_saturate = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      checks++;
      if (s_axis_tready !== 4'hF || m_axis_tvalid !== 1'b0) begin
        errors++; $display("FAIL skew_wait cycle %0d got sready %h mvalid %b exp f 0", c, s_axis_tready, m_axis_tvalid);
      end
      if (c < 3) drive(lanes(100, 1), lanes(200, 1), lanes(300, 1), lanes(400, 1), 4'b1011, 4'h0);
      else if (c == 3) drive(lanes(100, 1), lanes(200, 1), lanes(300, 1), lanes(400, 1), 4'hF, 4'h0);
      else drive(lanes(101, 1), lanes(201, 1), lanes(301, 1), lanes(401, 1), 4'hF, 4'hF);
      s_axis_tkeep[1*KW +: KW] = 64'hFFFF_FFFF_0000_FFFF;
      s_axis_tkeep[3*KW +: KW] = 64'h00FF_FFFF_FFFF_FFFF;
    end
    @(negedge aclk);
    idle();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== lanes(1000, 4) || m_axis_tkeep !== exp_keep || m_axis_tlast !== 1'b0) begin
      errors++; $display("FAIL skew_beat0 got v=%b %h keep %h exp %h keep %h", m_axis_tvalid, m_axis_tdata,
                         m_axis_tkeep, lanes(1000, 4), exp_keep);
    end
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== lanes(1004, 4) || m_axis_tlast !== 1'b1) begin
      errors++; $display("FAIL skew_beat1 got v=%b %h last %b exp %h last 1", m_axis_tvalid, m_axis_tdata,
                         m_axis_tlast, lanes(1004, 4));
    end
    @(negedge aclk);
    exp_beats += 2;
    checks++;
    if (m_axis_tvalid !== 1'b0 || stat_beat_count !== 32'(exp_beats)) begin
      errors++; $display("FAIL skew_end got v=%b count %0d exp v=0 count %0d", m_axis_tvalid, stat_beat_count, exp_beats);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] hold;
    logic          holding;
    logic          acc_now;
    logic          out_now;
    int            acc_b;
    int            out_b;
    int            cyc;
    holding = 1'b0;
    hold    = '0;
    acc_b   = 0;
    out_b   = 0;
    cyc     = 0;
    ctrl_constant = 32'd3;
    ctrl_saturate = 1'b0;
    while (out_b < 100 && cyc < 3000) begin
      @(negedge aclk);
      cyc++;
      if (holding) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold) begin
          errors++; $display("FAIL bp_stall cycle %0d got v=%b %h exp %h", cyc, m_axis_tvalid, m_axis_tdata, hold);
        end
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      if (acc_b < 100)
        drive(lanes(32'(acc_b*16 + 0), 1), lanes(32'(acc_b*16 + 1), 2), lanes(32'(acc_b*16 + 2), 3),
              lanes(32'(acc_b*16 + 3), 4), 4'hF, (acc_b % 10 == 9) ? 4'hF : 4'h0);
      else idle();
      #1;
      acc_now = (&s_axis_tvalid) & s_axis_tready[0];
      out_now = m_axis_tvalid & m_axis_tready;
      if (out_now) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra beat %0d got %h exp none", out_b, m_axis_tdata);
        end else begin
          if (m_axis_tdata !== exp_q[0]) begin
            errors++; $display("FAIL bp_data beat %0d got %h exp %h", out_b, m_axis_tdata, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        out_b++;
        holding = 1'b0;
      end else if (m_axis_tvalid) begin
        holding = 1'b1;
        hold    = m_axis_tdata;
      end else begin
        holding = 1'b0;
      end
      if (acc_now) begin
        exp_q.push_back(lanes(32'(64*acc_b + 9), 10));
        acc_b++;
      end
    end
    checks++;
    if (out_b != 100) begin
      errors++; $display("FAIL bp_timeout got %0d beats exp 100", out_b);
    end
    m_axis_tready = 1'b1;
    idle();
    @(negedge aclk);
    exp_beats += 100;
    checks++;
    if (stat_beat_count !== 32'(exp_beats) || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count got %0d left %0d exp %0d left 0", stat_beat_count, exp_q.size(), exp_beats);
    end
  endtask

  task automatic test_ctrl_change();
    logic          exp_v;
    logic [DW-1:0] exp_d;
    ctrl_saturate = 1'b0;
    m_axis_tready = 1'b1;
    checks++;
    if (stat_last_mismatch !== 1'b0) begin
      errors++; $display("FAIL mismatch_pre got %b exp 0", stat_last_mismatch);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      exp_v = (c >= 2) && (c <= 8);
      checks++;
      if (m_axis_tvalid !== exp_v) begin
        errors++; $display("FAIL ctrl_valid cycle %0d got %b exp %b", c, m_axis_tvalid, exp_v);
      end
      if (exp_v) begin
        exp_d = (c <= 7) ? lanes(32'd1, 32'd4) : lanes(32'd9, 32'd4);
        checks++;
        if (m_axis_tdata !== exp_d || m_axis_tlast !== (c >= 7)) begin
          errors++; $display("FAIL ctrl_beat cycle %0d got %h last %b exp %h last %b", c, m_axis_tdata,
                             m_axis_tlast, exp_d, (c >= 7));
        end
      end
      ctrl_constant = (c < 3) ? 32'd1 : 32'd9;
      if (c < 7) drive(lanes(0, 1), lanes(0, 1), lanes(0, 1), lanes(0, 1), 4'hF,
                       (c == 5) ? 4'b1101 : ((c == 6) ? 4'hF : 4'h0));
      else idle();
    end
    exp_beats += 7;
    checks++;
    if (stat_last_mismatch !== 1'b1) begin
      errors++; $display("FAIL mismatch_set got %b exp 1", stat_last_mismatch);
    end
    checks++;
    if (stat_beat_count !== 32'(exp_beats)) begin
      errors++; $display("FAIL ctrl_count got %0d exp %0d", stat_beat_count, exp_beats);
    end
  endtask

  task automatic test_reset_inflight();
    int n;
    @(negedge aclk);
    m_axis_tready = 1'b0;
    ctrl_constant = 32'd2;
    ctrl_saturate = 1'b0;
    drive(lanes(1, 0), lanes(1, 0), lanes(1, 0), lanes(1, 0), 4'hF, 4'h0);
    @(negedge aclk);
    drive(lanes(2, 0), lanes(2, 0), lanes(2, 0), lanes(2, 0), 4'hF, 4'h0);
    @(negedge aclk);
    idle();
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL inflight_valid got %b exp 1", m_axis_tvalid);
    end
    areset = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'h0) begin
      errors++; $display("FAIL async_reset got mvalid %b sready %h exp 0 0", m_axis_tvalid, s_axis_tready);
    end
    @(negedge aclk);
    areset        = 1'b0;
    m_axis_tready = 1'b1;
    exp_beats     = 0;
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || stat_beat_count !== 32'd0 || stat_last_mismatch !== 1'b0) begin
      errors++; $display("FAIL after_reset got v=%b count %0d mism %b exp 0 0 0", m_axis_tvalid, stat_beat_count,
                         stat_last_mismatch);
    end
    ctrl_constant = 32'd7;
    drive(lanes(10, 1), lanes(10, 1), lanes(10, 1), lanes(10, 1), 4'hF, 4'hF);
    @(negedge aclk);
    idle();
    ctrl_constant = 32'd2;
    n = 0;
    while (!m_axis_tvalid && n < 10) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL new_beat_timeout got v=%b exp 1", m_axis_tvalid);
    end else if (m_axis_tdata !== lanes(47, 4) || m_axis_tlast !== 1'b1) begin
      errors++; $display("FAIL new_beat got %h exp %h", m_axis_tdata, lanes(47, 4));
    end
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || stat_beat_count !== 32'd1) begin
      errors++; $display("FAIL new_beat_end got v=%b count %0d exp 0 1", m_axis_tvalid, stat_beat_count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_skew();
    test_backpressure();
    test_ctrl_change();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
